// File: rtl/fft_out_serializer_pkg.sv
// Shared types and constants for the FFT output serializer.
// Build option FFT_OUT_MAG_EN (defined in the other files) adds the magnitude estimate.
package fft_pkg;
   localparam int FFT_N     = 4;
   localparam int WORD_W    = 2 ** FFT_N;
   localparam int FRAME_LEN = 8;

   typedef enum logic {IDLE, STREAM} state_e;

   typedef struct packed {
      logic signed [WORD_W-1:0] re;
      logic signed [WORD_W-1:0] im;
   } cplx_t;
endpackage

// File: rtl/fft_out_serializer_if.sv
// Frame-in / bin-stream-out bundle for fft_out_serializer.
// out_mag exists only when FFT_OUT_MAG_EN is defined.
interface fft_out_serializer_if #(parameter int N = 4);
   localparam int W = 2 ** N;

   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] y0, y4;
   logic signed [W-1:0] yr1, yi1, yr2, yi2, yr3, yi3;
   logic signed [W-1:0] yr5, yi5, yr6, yi6, yr7, yi7;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] out_re, out_im;
   logic [2:0]          out_idx;
   logic                out_last;
`ifdef FFT_OUT_MAG_EN
   logic [W:0]          out_mag;
`endif

   modport slave (
      input  in_valid, y0, y4, yr1, yi1, yr2, yi2, yr3, yi3,
             yr5, yi5, yr6, yi6, yr7, yi7, out_ready,
      output in_ready, out_valid, out_re, out_im, out_idx, out_last
`ifdef FFT_OUT_MAG_EN
      , output out_mag
`endif
   );

   modport master (
      output in_valid, y0, y4, yr1, yi1, yr2, yi2, yr3, yi3,
             yr5, yi5, yr6, yi6, yr7, yi7, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_idx, out_last
`ifdef FFT_OUT_MAG_EN
      , input out_mag
`endif
   );
endinterface

// File: rtl/fft_mag_approx.sv
// Magnitude estimate max(|re|,|im|) + min(|re|,|im|)/2, saturating at W+1 bits.
// Used only when FFT_OUT_MAG_EN is defined.
module fft_mag_approx #(parameter int W = 16) (
   input  logic signed [W-1:0] re,
   input  logic signed [W-1:0] im,
   output logic        [W:0]   mag
);
   logic signed [W:0] re_x, im_x;
   logic        [W:0] abs_re, abs_im, mx, mn;
   logic      [W+1:0] sum;

   always_comb begin
      // one extra bit so the most negative input has a representable abs
      re_x   = {re[W-1], re};
      im_x   = {im[W-1], im};
      abs_re = (re_x < 0) ? $unsigned(-re_x) : $unsigned(re_x);
      abs_im = (im_x < 0) ? $unsigned(-im_x) : $unsigned(im_x);
      mx     = (abs_re >= abs_im) ? abs_re : abs_im;
      mn     = (abs_re >= abs_im) ? abs_im : abs_re;
      sum    = {1'b0, mx} + {2'b00, mn[W:1]};
      mag    = sum[W+1] ? '1 : sum[W:0];
   end
endmodule

// File: rtl/fft_out_serializer.sv
// Captures an 8-bin FFT frame in one cycle and streams it out one bin per cycle.
// Define FFT_OUT_MAG_EN to add the out_mag magnitude estimate.
//
// state  | meaning
// IDLE   | no frame held, ready to capture
// STREAM | frame held, emitting bin idx
module fft_out_serializer
   import fft_pkg::*;
#(
   parameter int N = FFT_N
) (
   input logic                 clk,
   input logic                 rst,
   fft_out_serializer_if.slave bus
);
   localparam int W = 2 ** N;

   state_e              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic signed [W-1:0] re_q [FRAME_LEN];
   logic signed [W-1:0] im_q [FRAME_LEN];
   logic signed [W-1:0] re_d [FRAME_LEN];
   logic signed [W-1:0] im_d [FRAME_LEN];
   logic signed [W-1:0] in_re [FRAME_LEN];
   logic signed [W-1:0] in_im [FRAME_LEN];
   logic                out_valid, fire, last_fire, in_ready, capture;

   always_comb begin
      in_re = '{bus.y0, bus.yr1, bus.yr2, bus.yr3, bus.y4, bus.yr5, bus.yr6, bus.yr7};
      in_im = '{'0, bus.yi1, bus.yi2, bus.yi3, '0, bus.yi5, bus.yi6, bus.yi7};
   end

   // in_ready looks through to out_ready so a new frame lands on the last beat
   assign out_valid = (state_q == STREAM);
   assign fire      = out_valid && bus.out_ready;
   assign last_fire = fire && (idx_q == 3'd7);
   assign in_ready  = (state_q == IDLE) || last_fire;
   assign capture   = bus.in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      re_d    = re_q;
      im_d    = im_q;
      if (capture) begin
         state_d = STREAM;
         idx_d   = 3'd0;
         re_d    = in_re;
         im_d    = in_im;
      end else if (last_fire) begin
         state_d = IDLE;
         idx_d   = 3'd0;
      end else if (fire) begin
         idx_d   = idx_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         for (int i = 0; i < FRAME_LEN; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         re_q    <= re_d;
         im_q    <= im_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_re    = re_q[idx_q];
   assign bus.out_im    = im_q[idx_q];
   assign bus.out_idx   = idx_q;
   assign bus.out_last  = out_valid && (idx_q == 3'd7);

`ifdef FFT_OUT_MAG_EN
   fft_mag_approx #(.W(W)) u_mag (
      .re  (re_q[idx_q]),
      .im  (im_q[idx_q]),
      .mag (bus.out_mag)
   );
`endif
endmodule

// File: tb/tb_fft_out_serializer.sv
// Table-driven bench for fft_out_serializer, plus a magnitude sequence under FFT_OUT_MAG_EN.
module tb_fft_out_serializer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass = 0;
   int   n_total = 0;

   fft_out_serializer_if #(.N(4)) bus ();

   fft_out_serializer #(.N(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst;
      logic iv;
      int   fr;
      logic ordy;
      logic chk_ir;
      logic exp_ir;
      logic exp_v;
      int   exp_idx;
      int   exp_fr;   // 7 = data not checked
   } vec_t;

   vec_t vecs[$];

   function automatic int re_of(int fr, int k);
      case (fr)
         1: return k + 1;
         2: return (k + 1) * 256;
         3: return -(k + 10);
         4: return (k == 1) ? -32768 : (k == 2) ? 3 : (k == 3) ? -32768 : k;
         default: return 0;
      endcase
   endfunction

   function automatic int im_of(int fr, int k);
      if (k == 0 || k == 4) return 0;
      case (fr)
         1: return -(k + 1);
         2: return 7 - k;
         3: return k * 3 + 1;
         4: return (k == 2) ? -4 : (k == 3) ? -32768 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic add(input logic r, input logic iv, input int fr, input logic ordy,
                      input logic chk_ir, input logic exp_ir, input logic exp_v,
                      input int exp_idx, input int exp_fr);
      vec_t v;
      v.rst = r; v.iv = iv; v.fr = fr; v.ordy = ordy;
      v.chk_ir = chk_ir; v.exp_ir = exp_ir; v.exp_v = exp_v;
      v.exp_idx = exp_idx; v.exp_fr = exp_fr;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
   endtask

   task automatic drive_frame(input int fr);
      bus.y0  = 16'(re_of(fr, 0));
      bus.y4  = 16'(re_of(fr, 4));
      bus.yr1 = 16'(re_of(fr, 1)); bus.yi1 = 16'(im_of(fr, 1));
      bus.yr2 = 16'(re_of(fr, 2)); bus.yi2 = 16'(im_of(fr, 2));
      bus.yr3 = 16'(re_of(fr, 3)); bus.yi3 = 16'(im_of(fr, 3));
      bus.yr5 = 16'(re_of(fr, 5)); bus.yi5 = 16'(im_of(fr, 5));
      bus.yr6 = 16'(re_of(fr, 6)); bus.yi6 = 16'(im_of(fr, 6));
      bus.yr7 = 16'(re_of(fr, 7)); bus.yi7 = 16'(im_of(fr, 7));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive_frame(0);

      // reset and idle
      add(1, 0, 0, 1, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 1, 1, 0, 0, 0);
      // single frame, out_ready high
      add(0, 1, 1, 1, 1, 1, 1, 0, 1);
      for (int k = 1; k < 8; k++) add(0, 0, 0, 1, 1, 0, 1, k, 1);
      add(0, 0, 0, 1, 1, 1, 0, 0, 7);
      add(0, 0, 0, 1, 1, 1, 0, 0, 7);
      // backpressure at idx 3 while upstream offers another frame
      add(0, 1, 2, 1, 1, 1, 1, 0, 2);
      for (int k = 1; k < 4; k++) add(0, 0, 0, 1, 1, 0, 1, k, 2);
      for (int k = 0; k < 3; k++) add(0, 1, 3, 0, 1, 0, 1, 3, 2);
      for (int k = 4; k < 8; k++) add(0, 1, 3, 1, 1, 0, 1, k, 2);
      // back-to-back frames 3 then 1 with no bubble
      add(0, 1, 3, 1, 1, 1, 1, 0, 3);
      for (int k = 1; k < 8; k++) add(0, 1, 1, 1, 1, 0, 1, k, 3);
      add(0, 1, 1, 1, 1, 1, 1, 0, 1);
      for (int k = 1; k < 6; k++) add(0, 0, 0, 1, 1, 0, 1, k, 1);
      // reset at idx 5 with a capture attempt, then restart
      add(1, 1, 2, 1, 1, 0, 0, 0, 0);
      add(0, 1, 2, 1, 1, 1, 1, 0, 2);
      add(0, 0, 0, 1, 1, 0, 1, 1, 2);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst           = vecs[i].rst;
         bus.in_valid  = vecs[i].iv;
         bus.out_ready = vecs[i].ordy;
         drive_frame(vecs[i].fr);
         #1;
         if (vecs[i].chk_ir) chk($sformatf("in_ready[%0d]", i), int'(bus.in_ready), int'(vecs[i].exp_ir));
         @(posedge clk);
         #1;
         chk($sformatf("out_valid[%0d]", i), int'(bus.out_valid), int'(vecs[i].exp_v));
         chk($sformatf("out_idx[%0d]", i), int'(bus.out_idx), vecs[i].exp_idx);
         chk($sformatf("out_last[%0d]", i), int'(bus.out_last),
             (vecs[i].exp_v && vecs[i].exp_idx == 7) ? 1 : 0);
         if (vecs[i].exp_fr != 7) begin
            chk($sformatf("out_re[%0d]", i), int'(bus.out_re), re_of(vecs[i].exp_fr, vecs[i].exp_idx));
            chk($sformatf("out_im[%0d]", i), int'(bus.out_im), im_of(vecs[i].exp_fr, vecs[i].exp_idx));
         end
      end

`ifdef FFT_OUT_MAG_EN
      begin
         int exp_mag[4] = '{0, 32768, 5, 49152};
         @(negedge clk);
         rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
         @(posedge clk); #1;
         chk("out_mag_reset", int'(bus.out_mag), 0);
         @(negedge clk);
         rst = 1'b0; bus.in_valid = 1'b1; drive_frame(4);
         @(posedge clk); #1;
         chk("out_mag[0]", int'(bus.out_mag), exp_mag[0]);
         @(negedge clk);
         bus.in_valid = 1'b0;
         for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mag_idx[%0d]", k), int'(bus.out_idx), k);
            chk($sformatf("out_mag[%0d]", k), int'(bus.out_mag), exp_mag[k]);
         end
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
